// File: rtl/key_schedule_seq.sv
// AES-128/192/256 key expansion, one word per clock; Ntot-Nk cycles from accept to done.
// Round keys are read back by index, either registered (1-cycle latency) or combinational.
module key_schedule_seq #(
  parameter int MAX_NK  = 8,
  parameter bit OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam int NW = 4 * (MAX_NK + 7);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] sh;
    sh = SBOX << {x, 3'b000};
    return sh[2047:2040];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [31:0]  w [NW];
  logic [5:0]   i;
  logic [2:0]   p;
  logic [7:0]   rcon;
  logic [3:0]   nk, nr;
  logic [3:0]   nk_sel, nr_sel;
  logic         legal;
  logic [31:0]  prev, far, sw_in, sw_out, temp, next_w;
  logic [5:0]   rb;
  logic [127:0] rd_c;

  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (mode)
      2'b01:   begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'b10:   begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: ;
    endcase
    legal = (mode != 2'b11) && (int'(nk_sel) <= MAX_NK);
  end

  // A single S-box bank serves both the RotWord path (p==0) and the AES-256 mid-key step.
  always_comb begin
    prev   = w[i - 6'd1];
    far    = w[i - {2'b00, nk}];
    sw_in  = (p == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sw_out = sub_word(sw_in);
    if (p == 3'd0)
      temp = sw_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && p == 3'd4)
      temp = sw_out;
    else
      temp = prev;
    next_w = far ^ temp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!busy && start && legal) begin
        for (int k = 0; k < MAX_NK; k++)
          if (k < int'(nk_sel)) w[k] <= key_in[255 - 32*k -: 32];
      end else if (busy) begin
        w[i] <= next_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      i          <= '0;
      p          <= '0;
      rcon       <= 8'h01;
      nk         <= 4'd4;
      nr         <= 4'd10;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!busy) begin
        if (start && legal) begin
          nk         <= nk_sel;
          nr         <= nr_sel;
          keys_valid <= 1'b0;
          busy       <= 1'b1;
          i          <= {2'b00, nk_sel};
          p          <= '0;
          rcon       <= 8'h01;
        end else if (start) begin
          err <= 1'b1;
        end
      end else begin
        if (p == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        p <= (p == 3'(nk - 4'd1)) ? 3'd0 : p + 3'd1;
        i <= i + 6'd1;
        // Last word of the schedule is index 4*Nr+3.
        if (i == {nr, 2'b11}) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rb   = {rd_round, 2'b00};
    rd_c = '0;
    if (keys_valid && rd_round <= nr)
      rd_c = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};
  end

  generate
    if (OUT_REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) rd_key <= '0;
        else     rd_key <= rd_c;
      end
    end else begin : g_comb
      assign rd_key = rd_c;
    end
  endgenerate
endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vectors, rejects, reset abort, back-to-back starts.
// A second instance (MAX_NK=4, combinational read) covers the key-length limit.
module tb_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst, start, start4;
  logic [1:0]   mode, mode4;
  logic [255:0] key_in;
  logic         busy, done, err, keys_valid;
  logic         busy4, done4, err4, keys_valid4;
  logic [3:0]   rd_round, rd_round4;
  logic [127:0] rd_key, rd_key4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q [$];
  logic [127:0] msk_q [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hfedcba9876543210};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] ALL = '1;

  always #5 clk = ~clk;

  key_schedule_seq #(.MAX_NK(8), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  key_schedule_seq #(.MAX_NK(4), .OUT_REG(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .key_in(key_in),
    .busy(busy4), .done(done4), .err(err4), .keys_valid(keys_valid4),
    .rd_round(rd_round4), .rd_key(rd_key4)
  );

  task automatic wait_done(input bit sel, output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if ((sel ? done4 : done) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic kick(input logic [1:0] m, input logic [255:0] k);
    mode = m; key_in = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; mode = 2'b00; mode4 = 2'b00;
    key_in = '0; rd_round = 4'd0; rd_round4 = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL reset_keys_valid: got %b want 0", keys_valid); end
    n_cmp++; if (rd_key !== 128'h0) begin n_bad++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
  endtask

  task automatic test_aes128;
    logic [3:0]   rr [4] = '{4'd0, 4'd11, 4'd1, 4'd10};
    logic [127:0] ee [4] = '{K128[255:128], 128'h0, 128'ha0fafe1788542cb123a339392a6c7605, R128_10};
    int n;
    kick(2'b00, K128);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL aes128_busy: got %b want 1", busy); end
    wait_done(1'b0, n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL aes128_latency: got %0d want 40", n); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL aes128_done_pulse: got %b want 0", done); end
    n_cmp++; if (keys_valid !== 1'b1) begin n_bad++; $display("FAIL aes128_keys_valid: got %b want 1", keys_valid); end
    for (int k = 0; k < 4; k++) begin
      rd_round = rr[k]; exp_q.push_back(ee[k]); msk_q.push_back(ALL);
      @(posedge clk); #1;
      n_cmp++;
      if ((rd_key & msk_q[0]) !== exp_q[0]) begin
        n_bad++; $display("FAIL aes128_rd r%0d: got %h want %h", rr[k], rd_key, exp_q[0]);
      end
      void'(exp_q.pop_front()); void'(msk_q.pop_front());
    end
    // Registered port must not follow a new index before the next edge.
    rd_round = 4'd1; #1;
    n_cmp++; if (rd_key !== R128_10) begin n_bad++; $display("FAIL aes128_rd_latency: got %h want %h", rd_key, R128_10); end
  endtask

  task automatic test_aes192;
    logic [3:0]   rr [4] = '{4'd0, 4'd1, 4'd12, 4'd13};
    logic [127:0] ee [4] = '{K192[255:128], {64'h62f8ead2522c6b7b, 64'h0}, R192_12, 128'h0};
    logic [127:0] mm [4] = '{ALL, {64'hffffffffffffffff, 64'h0}, ALL, ALL};
    int n;
    kick(2'b01, K192);
    wait_done(1'b0, n);
    n_cmp++; if (n !== 46) begin n_bad++; $display("FAIL aes192_latency: got %0d want 46", n); end
    for (int k = 0; k < 4; k++) begin
      rd_round = rr[k]; exp_q.push_back(ee[k]); msk_q.push_back(mm[k]);
      @(posedge clk); #1;
      n_cmp++;
      if ((rd_key & msk_q[0]) !== exp_q[0]) begin
        n_bad++; $display("FAIL aes192_rd r%0d: got %h want %h", rr[k], rd_key & msk_q[0], exp_q[0]);
      end
      void'(exp_q.pop_front()); void'(msk_q.pop_front());
    end
  endtask

  task automatic test_aes256;
    logic [3:0]   rr [4] = '{4'd0, 4'd1, 4'd14, 4'd15};
    logic [127:0] ee [4] = '{K256[255:128], K256[127:0], R256_14, 128'h0};
    int n;
    kick(2'b10, K256);
    wait_done(1'b0, n);
    n_cmp++; if (n !== 52) begin n_bad++; $display("FAIL aes256_latency: got %0d want 52", n); end
    for (int k = 0; k < 4; k++) begin
      rd_round = rr[k]; exp_q.push_back(ee[k]); msk_q.push_back(ALL);
      @(posedge clk); #1;
      n_cmp++;
      if ((rd_key & msk_q[0]) !== exp_q[0]) begin
        n_bad++; $display("FAIL aes256_rd r%0d: got %h want %h", rr[k], rd_key, exp_q[0]);
      end
      void'(exp_q.pop_front()); void'(msk_q.pop_front());
    end
  endtask

  task automatic test_reject;
    kick(2'b11, K128);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL reject_err: got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy: got %b want 0", busy); end
    n_cmp++; if (keys_valid !== 1'b1) begin n_bad++; $display("FAIL reject_keys_valid: got %b want 1", keys_valid); end
    rd_round = 4'd14; exp_q.push_back(R256_14);
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reject_err_pulse: got %b want 0", err); end
    n_cmp++;
    if (rd_key !== exp_q[0]) begin n_bad++; $display("FAIL reject_keys_kept: got %h want %h", rd_key, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_max_nk4;
    int n;
    mode4 = 2'b00; key_in = K128; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(1'b1, n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL nk4_latency: got %0d want 40", n); end
    rd_round4 = 4'd10; exp_q.push_back(R128_10); #1;
    n_cmp++;
    if (rd_key4 !== exp_q[0]) begin n_bad++; $display("FAIL nk4_comb_rd: got %h want %h", rd_key4, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_round4 = 4'd12; exp_q.push_back(128'h0); #1;
    n_cmp++;
    if (rd_key4 !== exp_q[0]) begin n_bad++; $display("FAIL nk4_rd_range: got %h want %h", rd_key4, exp_q[0]); end
    void'(exp_q.pop_front());
    mode4 = 2'b10; key_in = K256; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_cmp++; if (err4 !== 1'b1) begin n_bad++; $display("FAIL nk4_reject_err: got %b want 1", err4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL nk4_reject_busy: got %b want 0", busy4); end
    @(posedge clk); #1;
    n_cmp++; if (err4 !== 1'b0) begin n_bad++; $display("FAIL nk4_err_pulse: got %b want 0", err4); end
    rd_round4 = 4'd10; exp_q.push_back(R128_10); #1;
    n_cmp++;
    if (rd_key4 !== exp_q[0]) begin n_bad++; $display("FAIL nk4_keys_kept: got %h want %h", rd_key4, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_rst_mid;
    int n;
    bit saw_done = 1'b0;
    rd_round = 4'd14;
    kick(2'b10, K256);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_keys_valid: got %b want 0", keys_valid); end
    n_cmp++; if (rd_key !== 128'h0) begin n_bad++; $display("FAIL rstmid_rd_key: got %h want 0", rd_key); end
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
    n_cmp++; if (rd_key !== 128'h0) begin n_bad++; $display("FAIL rstmid_rd_key_late: got %h want 0", rd_key); end
    mode = 2'b00; key_in = K128; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_over_start: got %b want 0", busy); end
    kick(2'b00, K128);
    wait_done(1'b0, n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL rstmid_rerun_latency: got %0d want 40", n); end
    rd_round = 4'd10; exp_q.push_back(R128_10);
    @(posedge clk); #1;
    n_cmp++;
    if (rd_key !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_rerun_r10: got %h want %h", rd_key, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back;
    logic [3:0]   rr [3] = '{4'd0, 4'd12, 4'd13};
    logic [127:0] ee [3] = '{K192[255:128], R192_12, 128'h0};
    int n;
    mode = 2'b00; key_in = K128; start = 1'b1;
    @(posedge clk); #1;
    // Changing mode/key after accept must not disturb the AES-128 run.
    mode = 2'b01; key_in = K192;
    wait_done(1'b0, n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 40", n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_in_done: got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
    wait_done(1'b0, n);
    n_cmp++; if (n !== 46) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 46", n); end
    for (int k = 0; k < 3; k++) begin
      rd_round = rr[k]; exp_q.push_back(ee[k]);
      @(posedge clk); #1;
      n_cmp++;
      if (rd_key !== exp_q[0]) begin
        n_bad++; $display("FAIL b2b_rd r%0d: got %h want %h", rr[k], rd_key, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset;
    test_aes128;
    test_aes192;
    test_aes256;
    test_reject;
    test_max_nk4;
    test_rst_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
